// File: rtl/alu.sv
// Registered integer ALU: eight opcodes, result and flags registered with
// one-cycle latency. A new operation can be issued every cycle.
// Optional feature: define ALU_SAT_EN to make ADD/SUB saturate as unsigned
// operations. OVF is still taken from the unsaturated value.
module alu #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [2:0]       OPCODE,
  input  logic [WIDTH-1:0] OP1,
  input  logic [WIDTH-1:0] OP2,
  output logic [WIDTH-1:0] RESULT,
  output logic             CARRY,
  output logic             ZERO,
  output logic             NEG,
  output logic             OVF,
  output logic             VALID
);

  typedef enum logic [2:0] {
    OpAdd = 3'b000,
    OpSub = 3'b001,
    OpAnd = 3'b010,
    OpOr  = 3'b011,
    OpXor = 3'b100,
    OpNot = 3'b101,
    OpShl = 3'b110,
    OpShr = 3'b111
  } op_e;

  logic [WIDTH-1:0] result_d, result_q;
  logic             carry_d, carry_q;
  logic             ovf_d, ovf_q;
  logic             valid_q;

  // Extra top bit holds carry-out (ADD) or borrow (SUB).
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             add_ovf;
  logic             sub_ovf;

  // Wide add/subtract and their signed-overflow terms.
  always_comb begin
    sum     = {1'b0, OP1} + {1'b0, OP2};
    diff    = {1'b0, OP1} - {1'b0, OP2};
    add_ovf = (OP1[WIDTH-1] == OP2[WIDTH-1]) && (sum[WIDTH-1] != OP1[WIDTH-1]);
    sub_ovf = (OP1[WIDTH-1] != OP2[WIDTH-1]) && (diff[WIDTH-1] != OP1[WIDTH-1]);
  end

  // Next result, carry and overflow selected by opcode.
  always_comb begin
    result_d = '0;
    carry_d  = 1'b0;
    ovf_d    = 1'b0;
    unique case (op_e'(OPCODE))
      OpAdd: begin
        carry_d = sum[WIDTH];
        ovf_d   = add_ovf;
`ifdef ALU_SAT_EN
        result_d = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
        result_d = sum[WIDTH-1:0];
`endif
      end
      OpSub: begin
        carry_d = diff[WIDTH];
        ovf_d   = sub_ovf;
`ifdef ALU_SAT_EN
        result_d = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
`else
        result_d = diff[WIDTH-1:0];
`endif
      end
      OpAnd: result_d = OP1 & OP2;
      OpOr:  result_d = OP1 | OP2;
      OpXor: result_d = OP1 ^ OP2;
      OpNot: result_d = ~OP1;
      OpShl: begin
        result_d = {OP1[WIDTH-2:0], 1'b0};
        carry_d  = OP1[WIDTH-1];
      end
      OpShr: begin
        result_d = {1'b0, OP1[WIDTH-1:1]};
        carry_d  = OP1[0];
      end
      default: begin
        result_d = '0;
        carry_d  = 1'b0;
        ovf_d    = 1'b0;
      end
    endcase
  end

  // Output registers; reset wins over any operation at the same edge.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      valid_q  <= 1'b1;
    end
  end

  // ZERO and NEG follow the registered result, but are forced low while not valid.
  always_comb begin
    RESULT = result_q;
    CARRY  = carry_q;
    OVF    = ovf_q;
    VALID  = valid_q;
    ZERO   = valid_q && (result_q == '0);
    NEG    = result_q[WIDTH-1];
  end

`ifndef SYNTHESIS
  // Per-opcode properties, checked one cycle after issue.
  a_reset: assert property (@(posedge clk)
    !rstn |=> (RESULT == '0) && !CARRY && !ZERO && !NEG && !OVF && !VALID);
  a_flags: assert property (@(posedge clk)
    VALID |-> (ZERO == (RESULT == '0)) && (NEG == RESULT[WIDTH-1]));
  a_and: assert property (@(posedge clk)
    (rstn && OPCODE == 3'b010) |=> (RESULT == $past(OP1 & OP2)) && !CARRY && !OVF);
  a_or: assert property (@(posedge clk)
    (rstn && OPCODE == 3'b011) |=> (RESULT == $past(OP1 | OP2)) && !CARRY && !OVF);
  a_xor: assert property (@(posedge clk)
    (rstn && OPCODE == 3'b100) |=> (RESULT == $past(OP1 ^ OP2)) && !CARRY && !OVF);
  a_not: assert property (@(posedge clk)
    (rstn && OPCODE == 3'b101) |=> (RESULT == $past(~OP1)) && !CARRY && !OVF);
  a_shl: assert property (@(posedge clk)
    (rstn && OPCODE == 3'b110) |=>
      (RESULT == $past({OP1[WIDTH-2:0], 1'b0})) && (CARRY == $past(OP1[WIDTH-1])) && !OVF);
  a_shr: assert property (@(posedge clk)
    (rstn && OPCODE == 3'b111) |=>
      (RESULT == $past({1'b0, OP1[WIDTH-1:1]})) && (CARRY == $past(OP1[0])) && !OVF);
  a_add_c: assert property (@(posedge clk)
    (rstn && OPCODE == 3'b000) |=> (CARRY == $past(sum[WIDTH])) && (OVF == $past(add_ovf)));
  a_sub_c: assert property (@(posedge clk)
    (rstn && OPCODE == 3'b001) |=> (CARRY == $past(OP1 < OP2)) && (OVF == $past(sub_ovf)));
`ifdef ALU_SAT_EN
  a_add_r: assert property (@(posedge clk)
    (rstn && OPCODE == 3'b000) |=>
      (RESULT == (CARRY ? {WIDTH{1'b1}} : $past(sum[WIDTH-1:0]))));
  a_sub_r: assert property (@(posedge clk)
    (rstn && OPCODE == 3'b001) |=> (RESULT == (CARRY ? '0 : $past(diff[WIDTH-1:0]))));
`else
  a_add_r: assert property (@(posedge clk)
    (rstn && OPCODE == 3'b000) |=> (RESULT == $past(sum[WIDTH-1:0])));
  a_sub_r: assert property (@(posedge clk)
    (rstn && OPCODE == 3'b001) |=> (RESULT == $past(diff[WIDTH-1:0])));
`endif
`endif

endmodule

// File: tb/tb_alu.sv
// Bench for alu: directed cases followed by random operations, each compared
// against an arithmetic reference model.
module tb_alu;

  logic       clk;
  logic       rstn;
  logic [2:0] OPCODE;
  logic [3:0] OP1;
  logic [3:0] OP2;
  logic [3:0] RESULT;
  logic       CARRY;
  logic       ZERO;
  logic       NEG;
  logic       OVF;
  logic       VALID;

  int vectors;
  int miscompares;
  int checks;

  alu #(.WIDTH(4)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .OPCODE (OPCODE),
    .OP1    (OP1),
    .OP2    (OP2),
    .RESULT (RESULT),
    .CARRY  (CARRY),
    .ZERO   (ZERO),
    .NEG    (NEG),
    .OVF    (OVF),
    .VALID  (VALID)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sgn(input int v);
    return (v >= 8) ? v - 16 : v;
  endfunction

  // Reference: integer arithmetic on unsigned / two's-complement readings.
  function automatic void model(input int op, input int a, input int b,
                                output int res, output int cy, output int ovf);
    int s;
    res = 0;
    cy  = 0;
    ovf = 0;
    case (op)
      0: begin
        s   = a + b;
        cy  = (s > 15) ? 1 : 0;
        res = s % 16;
        ovf = ((sgn(a) + sgn(b)) > 7 || (sgn(a) + sgn(b)) < -8) ? 1 : 0;
`ifdef ALU_SAT_EN
        if (cy == 1) res = 15;
`endif
      end
      1: begin
        cy  = (a < b) ? 1 : 0;
        res = (a - b + 16) % 16;
        ovf = ((sgn(a) - sgn(b)) > 7 || (sgn(a) - sgn(b)) < -8) ? 1 : 0;
`ifdef ALU_SAT_EN
        if (cy == 1) res = 0;
`endif
      end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: res = 15 - a;
      6: begin res = (a * 2) % 16; cy = (a >= 8) ? 1 : 0; end
      default: begin res = a / 2; cy = a % 2; end
    endcase
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one operation (or reset), wait one edge, compare every output.
  task automatic step(input bit rn, input int op, input int a, input int b,
                      input string tag);
    int er, ec, eo;
    rstn   = rn;
    OPCODE = 3'(op);
    OP1    = 4'(a);
    OP2    = 4'(b);
    @(posedge clk);
    #1;
    vectors++;
    if (rn) begin
      model(op, a, b, er, ec, eo);
      check({tag, ".result"}, int'(RESULT), er);
      check({tag, ".carry"},  int'(CARRY),  ec);
      check({tag, ".zero"},   int'(ZERO),   (er == 0) ? 1 : 0);
      check({tag, ".neg"},    int'(NEG),    (er >= 8) ? 1 : 0);
      check({tag, ".ovf"},    int'(OVF),    eo);
      check({tag, ".valid"},  int'(VALID),  1);
    end else begin
      check({tag, ".result"}, int'(RESULT), 0);
      check({tag, ".carry"},  int'(CARRY),  0);
      check({tag, ".zero"},   int'(ZERO),   0);
      check({tag, ".neg"},    int'(NEG),    0);
      check({tag, ".ovf"},    int'(OVF),    0);
      check({tag, ".valid"},  int'(VALID),  0);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    checks      = 0;
    rstn   = 1'b0;
    OPCODE = 3'b000;
    OP1    = 4'h0;
    OP2    = 4'h0;

    step(1'b0, 0, 15, 1, "rst0");
    step(1'b0, 3, 5, 10, "rst1");
    step(1'b1, 7, 4'b0100, 4'b1010, "shr");
    step(1'b1, 0, 15, 1, "add_wrap");
    check("add_wrap.lit_carry", int'(CARRY), 1);
`ifdef ALU_SAT_EN
    check("add_wrap.lit_result", int'(RESULT), 15);
`else
    check("add_wrap.lit_result", int'(RESULT), 0);
`endif
    step(1'b1, 0, 7, 1, "add_ovf");
    check("add_ovf.lit_result", int'(RESULT), 8);
    check("add_ovf.lit_ovf", int'(OVF), 1);
    step(1'b1, 1, 2, 5, "sub_borrow");
    check("sub_borrow.lit_carry", int'(CARRY), 1);
    step(1'b1, 1, 8, 1, "sub_ovf");
    step(1'b1, 4, 10, 5, "xor");
    check("xor.lit_result", int'(RESULT), 15);
    step(1'b1, 6, 9, 3, "shl");
    check("shl.lit_result", int'(RESULT), 2);
    check("shl.lit_carry", int'(CARRY), 1);
    step(1'b1, 4, 10, 5, "xor2");
    step(1'b0, 6, 9, 3, "mid_rst");
    step(1'b1, 2, 12, 10, "and_after_rst");
    step(1'b1, 5, 6, 0, "not");
    step(1'b1, 3, 0, 0, "or_zero");

    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 19) != 0), int'($urandom_range(0, 7)),
           int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
